// File: rtl/spad_frontend_mc.sv
// spad_frontend_mc
// Clocked multi-channel SPAD front-end for the TDC path. Samples NCH photon
// pulses on clk_250M, applies per-channel dead time and a coincidence
// threshold, and accepts up to MAX_EVT events per TDC measurement window.
//
// Optional build macro: SPAD_INT_ACCUM_EN
//   defined   : spad_int accumulates hits of every accepted event and
//               saturates at all-ones (cleared only by rst_auto).
//   undefined : spad_int holds the hit count of the last accepted event.
//
// The FSM state is kept in the internal signal 'state' (IDLE/ARMED/DONE)
// so checkers can bind to it directly.
module spad_frontend_mc #(
  parameter int NCH      = 16,
  parameter int INT_W    = 16,
  parameter int EVT_W    = 2,
  parameter int DEAD_CYC = 4,
  parameter int GATE_CYC = 1,
  parameter int WIN_CYC  = 512,
  parameter int MAX_EVT  = 3,
  parameter int COIN_TH  = 1
) (
  input  logic             clk_250M,
  input  logic             rst_auto,
  input  logic             tdc_start,
  input  logic [NCH-1:0]   photon,
  output logic             trig,
  output logic             time_gate,
  output logic [INT_W-1:0] spad_int,
  output logic [NCH-1:0]   ch_mask,
  output logic [EVT_W-1:0] evt_cnt,
  output logic             win_done
);

  // Counter widths: dead counter holds DEAD_CYC, gate counter holds the
  // remaining cycles after the first (GATE_CYC-1), window counter holds
  // WIN_CYC-1. Each is at least one bit wide.
  localparam int DEAD_W = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  localparam int GATE_W = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam int WIN_W  = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;

  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYC - 1);
  localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(WIN_CYC - 1);
  localparam logic [INT_W-1:0]  COIN_VAL  = INT_W'(COIN_TH);
  localparam logic [EVT_W-1:0]  EVT_MAX   = EVT_W'(MAX_EVT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic              start_d;
  logic [WIN_W-1:0]  win_cnt;
  logic [GATE_W-1:0] gate_rem;
  logic [DEAD_W-1:0] dead_cnt [NCH];

  logic [NCH-1:0]    live;
  logic [NCH-1:0]    fire;
  logic [INT_W-1:0]  hits;
  logic              accept;
  logic [EVT_W-1:0]  evt_next;
  logic [INT_W-1:0]  int_next;

  // Live/fire vector, coincidence count and accept decision for this cycle.
  always_comb begin
    live = '0;
    hits = '0;
    for (int i = 0; i < NCH; i++) begin
      live[i] = (dead_cnt[i] == '0);
    end
    fire = photon & live;
    for (int i = 0; i < NCH; i++) begin
      hits = hits + INT_W'(fire[i]);
    end
    accept   = (state == ARMED) && (hits >= COIN_VAL) && (evt_cnt < EVT_MAX);
    evt_next = evt_cnt + EVT_W'(1);
  end

`ifdef SPAD_INT_ACCUM_EN
  logic [INT_W:0] int_sum;

  // Saturating accumulation of hits across accepted events.
  always_comb begin
    int_sum  = {1'b0, spad_int} + {1'b0, hits};
    int_next = int_sum[INT_W] ? {INT_W{1'b1}} : int_sum[INT_W-1:0];
  end
`else
  // Intensity is simply the hit count of the accepted event.
  always_comb begin
    int_next = hits;
  end
`endif

  // Per-channel dead time: reload on every fire regardless of FSM state.
  always_ff @(posedge clk_250M or posedge rst_auto) begin
    if (rst_auto) begin
      for (int i = 0; i < NCH; i++) begin
        dead_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (fire[i]) begin
          dead_cnt[i] <= DEAD_LOAD;
        end else if (dead_cnt[i] != '0) begin
          dead_cnt[i] <= dead_cnt[i] - DEAD_W'(1);
        end
      end
    end
  end

  // Window FSM plus the registered event outputs it gates.
  always_ff @(posedge clk_250M or posedge rst_auto) begin
    if (rst_auto) begin
      state    <= IDLE;
      start_d  <= 1'b1;  // a start held high through reset must re-rise
      win_cnt  <= '0;
      evt_cnt  <= '0;
      win_done <= 1'b0;
      trig     <= 1'b0;
      spad_int <= '0;
      ch_mask  <= '0;
    end else begin
      start_d  <= tdc_start;
      win_done <= 1'b0;
      if (accept) begin
        trig     <= 1'b1;
        ch_mask  <= fire;
        spad_int <= int_next;
        evt_cnt  <= evt_next;
      end
      case (state)
        IDLE: begin
          if (tdc_start && !start_d) begin
            state   <= ARMED;
            evt_cnt <= '0;
            win_cnt <= WIN_LOAD;
          end
        end
        ARMED: begin
          if (win_cnt != '0) begin
            win_cnt <= win_cnt - WIN_W'(1);
          end
          // An accept on the last window cycle still counts (above).
          if ((win_cnt == '0) || (accept && (evt_next == EVT_MAX))) begin
            state    <= DONE;
            win_done <= 1'b1;
          end
        end
        DONE: begin
          if (!tdc_start) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // time_gate pulse of GATE_CYC cycles; a new accept restarts it.
  always_ff @(posedge clk_250M or posedge rst_auto) begin
    if (rst_auto) begin
      time_gate <= 1'b0;
      gate_rem  <= '0;
    end else if (accept) begin
      time_gate <= 1'b1;
      gate_rem  <= GATE_LOAD;
    end else if (gate_rem != '0) begin
      time_gate <= 1'b1;
      gate_rem  <= gate_rem - GATE_W'(1);
    end else begin
      time_gate <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spad_frontend_mc.sv
// tb_spad_frontend_mc
// Table-driven and randomized bench for spad_frontend_mc. The main instance
// uses default parameters and is checked every cycle against a reference
// model built on absolute cycle times (channel next-live time, window end
// time, gate end time). Two small instances cover the coincidence threshold,
// gate reload and intensity width/saturation corner cases.
// Honours SPAD_INT_ACCUM_EN in its expectations.
module tb_spad_frontend_mc;

  localparam int NCH      = 16;
  localparam int INT_W    = 16;
  localparam int EVT_W    = 2;
  localparam int DEAD_CYC = 4;
  localparam int GATE_CYC = 1;
  localparam int WIN_CYC  = 512;
  localparam int MAX_EVT  = 3;
  localparam int COIN_TH  = 1;

  // ---------------- clock / reset ----------------
  logic clk_250M = 1'b0;
  logic rst_auto = 1'b1;
  always #2 clk_250M = ~clk_250M;

  // ---------------- main DUT ----------------
  logic             tdc_start = 1'b0;
  logic [NCH-1:0]   photon    = '0;
  logic             trig, time_gate, win_done;
  logic [INT_W-1:0] spad_int;
  logic [NCH-1:0]   ch_mask;
  logic [EVT_W-1:0] evt_cnt;

  spad_frontend_mc #(
    .NCH(NCH), .INT_W(INT_W), .EVT_W(EVT_W), .DEAD_CYC(DEAD_CYC),
    .GATE_CYC(GATE_CYC), .WIN_CYC(WIN_CYC), .MAX_EVT(MAX_EVT), .COIN_TH(COIN_TH)
  ) dut (
    .clk_250M(clk_250M), .rst_auto(rst_auto), .tdc_start(tdc_start),
    .photon(photon), .trig(trig), .time_gate(time_gate), .spad_int(spad_int),
    .ch_mask(ch_mask), .evt_cnt(evt_cnt), .win_done(win_done)
  );

  // ---------------- instance B: COIN_TH=3, GATE_CYC=2 ----------------
  logic       b_start = 1'b0;
  logic [2:0] b_ph = '0;
  logic       b_trig, b_tg, b_wd;
  logic [1:0] b_int, b_evt;
  logic [2:0] b_mask;

  spad_frontend_mc #(
    .NCH(3), .INT_W(2), .EVT_W(2), .DEAD_CYC(0),
    .GATE_CYC(2), .WIN_CYC(16), .MAX_EVT(3), .COIN_TH(3)
  ) u_b (
    .clk_250M(clk_250M), .rst_auto(rst_auto), .tdc_start(b_start),
    .photon(b_ph), .trig(b_trig), .time_gate(b_tg), .spad_int(b_int),
    .ch_mask(b_mask), .evt_cnt(b_evt), .win_done(b_wd)
  );

  // ---------------- instance C: INT_W=2, COIN_TH=2 ----------------
  logic       c_start = 1'b0;
  logic [2:0] c_ph = '0;
  logic       c_trig, c_tg, c_wd;
  logic [1:0] c_int, c_evt;
  logic [2:0] c_mask;

  spad_frontend_mc #(
    .NCH(3), .INT_W(2), .EVT_W(2), .DEAD_CYC(0),
    .GATE_CYC(1), .WIN_CYC(16), .MAX_EVT(3), .COIN_TH(2)
  ) u_c (
    .clk_250M(clk_250M), .rst_auto(rst_auto), .tdc_start(c_start),
    .photon(c_ph), .trig(c_trig), .time_gate(c_tg), .spad_int(c_int),
    .ch_mask(c_mask), .evt_cnt(c_evt), .win_done(c_wd)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time-based view: a channel is live once the cycle index reaches its
  // next_live time; the window closes at edge win_end; the gate is high
  // while the edge index is below gate_until.
  int              t = 0;
  int              next_live [NCH];
  int              phase = 0;        // 0 idle, 1 window open, 2 closed
  int              win_end = 0;
  bit              prev_st = 1'b1;
  int              m_evt = 0;
  bit              m_trig = 1'b0;
  longint          m_int = 0;
  logic [NCH-1:0]  m_mask = '0;
  int              gate_until = 0;
  bit              m_tg = 1'b0;
  bit              m_wd = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) next_live[i] = 0;
    phase = 0; win_end = 0; prev_st = 1'b1; m_evt = 0; m_trig = 1'b0;
    m_int = 0; m_mask = '0; gate_until = 0; m_tg = 1'b0; m_wd = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic [NCH-1:0] ph);
    logic [NCH-1:0] f;
    int h;
    bit acc;
    longint cap;
    t++;
    f = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ph[i] && (t >= next_live[i])) begin
        f[i] = 1'b1;
        next_live[i] = t + DEAD_CYC + 1;
      end
    end
    h   = $countones(f);
    acc = (phase == 1) && (h >= COIN_TH) && (m_evt < MAX_EVT);
    m_wd = 1'b0;
    if (acc) begin
      m_evt++;
      m_trig = 1'b1;
      m_mask = f;
`ifdef SPAD_INT_ACCUM_EN
      cap   = (longint'(1) << INT_W) - 1;
      m_int = (m_int + h > cap) ? cap : m_int + h;
`else
      cap   = 0;
      m_int = h;
`endif
      gate_until = t + GATE_CYC;
    end
    m_tg = (t < gate_until);
    if (phase == 0) begin
      if (st && !prev_st) begin
        phase = 1; m_evt = 0; win_end = t + WIN_CYC;
      end
    end else if (phase == 1) begin
      if ((t == win_end) || (acc && m_evt == MAX_EVT)) begin
        phase = 2; m_wd = 1'b1;
      end
    end else begin
      if (!st) phase = 0;
    end
    prev_st = st;
  endtask

  task automatic check_all();
    chk("trig",      64'(trig),      64'(m_trig));
    chk("time_gate", 64'(time_gate), 64'(m_tg));
    chk("spad_int",  64'(spad_int),  64'(m_int));
    chk("ch_mask",   64'(ch_mask),   64'(m_mask));
    chk("evt_cnt",   64'(evt_cnt),   64'(m_evt));
    chk("win_done",  64'(win_done),  64'(m_wd));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // at the same offset after the next rising edge.
  task automatic step(input logic st, input logic [NCH-1:0] ph);
    tdc_start = st;
    photon    = ph;
    @(posedge clk_250M);
    model_edge(st, ph);
    #1;
    check_all();
  endtask

  task automatic do_reset(input logic st_hold);
    rst_auto  = 1'b1;
    tdc_start = st_hold;
    photon    = '0;
    repeat (3) @(posedge clk_250M);
    #1;
    model_reset();
    check_all();
    rst_auto = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int               cyc;
    logic [NCH-1:0]   ph;
    logic             e_trig;
    logic             e_tg;
    logic [INT_W-1:0] e_int;
    logic [NCH-1:0]   e_mask;
    logic [EVT_W-1:0] e_evt;
    logic             e_wd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(int cyc, logic [NCH-1:0] ph, logic tr, logic tg,
                              int iv, logic [NCH-1:0] msk, int ev, logic wd);
    vec_t v;
    v.cyc = cyc; v.ph = ph; v.e_trig = tr; v.e_tg = tg;
    v.e_int = INT_W'(iv); v.e_mask = msk; v.e_evt = EVT_W'(ev); v.e_wd = wd;
    return v;
  endfunction

  // Drops tdc_start, raises it (arm edge = cycle 0), then runs cycles
  // 1..ncyc applying table photons and checking table rows at their cycle.
  task automatic run_table(input string tag, input int ncyc);
    logic [NCH-1:0] ph;
    step(1'b0, '0);
    step(1'b1, '0);
    for (int c = 1; c <= ncyc; c++) begin
      ph = '0;
      foreach (vt[k]) if (vt[k].cyc == c) ph = vt[k].ph;
      step(1'b1, ph);
      foreach (vt[k]) begin
        if (vt[k].cyc == c) begin
          chk($sformatf("%s_c%0d_trig", tag, c), 64'(trig),      64'(vt[k].e_trig));
          chk($sformatf("%s_c%0d_gate", tag, c), 64'(time_gate), 64'(vt[k].e_tg));
          chk($sformatf("%s_c%0d_int",  tag, c), 64'(spad_int),  64'(vt[k].e_int));
          chk($sformatf("%s_c%0d_mask", tag, c), 64'(ch_mask),   64'(vt[k].e_mask));
          chk($sformatf("%s_c%0d_evt",  tag, c), 64'(evt_cnt),   64'(vt[k].e_evt));
          chk($sformatf("%s_c%0d_wd",   tag, c), 64'(win_done),  64'(vt[k].e_wd));
        end
      end
    end
    vt.delete();
  endtask

  // Small-instance helper: one clock with the given photons, then sample.
  task automatic tick_bc();
    @(posedge clk_250M);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin : main_seq
    int hold;
    int mode;
    logic st_r;
    logic [NCH-1:0] ph;
    int i1, i2, i3, i4, i5, i6;

`ifdef SPAD_INT_ACCUM_EN
    i1 = 1; i2 = 3; i3 = 4; i4 = 5; i5 = 6; i6 = 6;
`else
    i1 = 1; i2 = 2; i3 = 1; i4 = 1; i5 = 1; i6 = 1;
`endif

    // Reset state
    do_reset(1'b0);

    // Basic three-event window, closes early at MAX_EVT
    vt.push_back(mk(5,  16'h0000, 0, 0, 0,  16'h0000, 0, 0));
    vt.push_back(mk(10, 16'h0001, 1, 1, i1, 16'h0001, 1, 0));
    vt.push_back(mk(11, 16'h0000, 1, 0, i1, 16'h0001, 1, 0));
    vt.push_back(mk(20, 16'h0003, 1, 1, i2, 16'h0003, 2, 0));
    vt.push_back(mk(21, 16'h0000, 1, 0, i2, 16'h0003, 2, 0));
    vt.push_back(mk(30, 16'h0100, 1, 1, i3, 16'h0100, 3, 1));
    vt.push_back(mk(31, 16'h0000, 1, 0, i3, 16'h0100, 3, 0));
    run_table("basic", 35);

    // Dead time with photon[0] held, then full window expiry
    for (int c = 5; c <= 9; c++)
      vt.push_back(mk(c, 16'h0001, 1, (c == 5), i4, 16'h0001, 1, 0));
    vt.push_back(mk(10,          16'h0001, 1, 1, i5, 16'h0001, 2, 0));
    vt.push_back(mk(11,          16'h0000, 1, 0, i5, 16'h0001, 2, 0));
    vt.push_back(mk(WIN_CYC - 1, 16'h0000, 1, 0, i6, 16'h0001, 2, 0));
    vt.push_back(mk(WIN_CYC,     16'h0000, 1, 0, i6, 16'h0001, 2, 1));
    run_table("dead", WIN_CYC + 1);

    // Reset mid-window with tdc_start held high: no re-arm afterwards
    step(1'b0, '0);
    step(1'b1, '0);
    step(1'b1, 16'h0010);
    do_reset(1'b1);
    for (int c = 0; c < 20; c++) step(1'b1, 16'h00ff);
    chk("rst_hold_no_arm_evt",  64'(evt_cnt), 64'(0));
    chk("rst_hold_no_arm_trig", 64'(trig),    64'(0));

    // Window expiry with no photons after a fresh rise
    vt.push_back(mk(WIN_CYC - 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
    vt.push_back(mk(WIN_CYC,     16'h0000, 0, 0, 0, 16'h0000, 0, 1));
    vt.push_back(mk(WIN_CYC + 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
    run_table("expiry", WIN_CYC + 1);

    // Randomized traffic against the model
    hold = 0;
    st_r = 1'b0;
    mode = 0;
    for (int n = 0; n < 6000; n++) begin
      if (n % 700 == 0) mode = $urandom_range(0, 2);
      if (hold == 0) begin
        st_r = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 60);
      end
      hold--;
      case (mode)
        0: ph = ($urandom_range(0, 7) == 0) ?
                (NCH'($urandom) & NCH'($urandom) & NCH'($urandom)) : '0;
        1: ph = NCH'($urandom);
        default: ph = '0;
      endcase
      step(st_r, ph);
    end
    tdc_start = 1'b0;
    photon    = '0;

    // Coincidence threshold 3 and gate reload (instance B)
    b_start = 1'b1; tick_bc();
    b_ph = 3'b011; tick_bc();
    chk("coin_b_reject_trig", 64'(b_trig), 64'(0));
    chk("coin_b_reject_evt",  64'(b_evt),  64'(0));
    b_ph = 3'b111; tick_bc();
    chk("coin_b_trig", 64'(b_trig), 64'(1));
    chk("coin_b_int",  64'(b_int),  64'(3));
    chk("coin_b_mask", 64'(b_mask), 64'(7));
    chk("coin_b_evt1", 64'(b_evt),  64'(1));
    chk("coin_b_gate", 64'(b_tg),   64'(1));
    b_ph = 3'b111; tick_bc();
    chk("coin_b_evt2", 64'(b_evt), 64'(2));
    b_ph = 3'b000; tick_bc();
    chk("coin_b_gate_reload", 64'(b_tg), 64'(1));
    tick_bc();
    chk("coin_b_gate_end", 64'(b_tg), 64'(0));
    b_ph = 3'b111; tick_bc();
    chk("coin_b_evt3", 64'(b_evt), 64'(3));
    chk("coin_b_wd",   64'(b_wd),  64'(1));
    b_ph = 3'b111; tick_bc();
    chk("coin_b_done_evt", 64'(b_evt), 64'(3));
    chk("coin_b_wd_pulse", 64'(b_wd),  64'(0));
    b_ph = 3'b000;

    // Two-bit intensity: hold or saturate (instance C)
    c_start = 1'b1; tick_bc();
    c_ph = 3'b011; tick_bc();
    chk("int2_a", 64'(c_int), 64'(2));
    tick_bc();
`ifdef SPAD_INT_ACCUM_EN
    chk("int2_b", 64'(c_int), 64'(3));
`else
    chk("int2_b", 64'(c_int), 64'(2));
`endif
    tick_bc();
`ifdef SPAD_INT_ACCUM_EN
    chk("int2_c", 64'(c_int), 64'(3));
`else
    chk("int2_c", 64'(c_int), 64'(2));
`endif
    chk("int2_evt", 64'(c_evt), 64'(3));
    chk("int2_wd",  64'(c_wd),  64'(1));
    c_ph = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
